ram_io_controller: RTL

- Parametrised, multi-cycle successor to the single-cycle RAM controller. Sits between the CPU's memory-command interface (mem_cmd/mem_addr) and an internal synchronous RAM plus two memory-mapped I/O registers (LED output, switch input).
- Adds programmable wait states, a busy/ready handshake and an error flag for unmapped accesses.
- Read data is driven through a registered mux with no tri-state.

---
 rtl/ram_io_controller.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ram_io_controller.sv
// Multi-cycle RAM/I-O controller: programmable wait states, busy/ready handshake,
// error flag for unmapped accesses, registered read-data mux.
`default_nettype none

module ram_io_controller #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 9,
  parameter int RAM_AW      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] IO_LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] IO_SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] led_out,
  output logic              mem_busy,
  output logic              mem_ready,
  output logic              mem_err,
  output logic [1:0]        state_dbg
);

  // Handshake: a command is accepted only at an edge where the block is idle
  // (mem_busy=0) and mem_cmd is MREAD/MWRITE; the access completes with a single
  // mem_ready pulse, during which mem_err and (for reads) read_data are valid.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic [1:0]        state;
  logic [3:0]        wait_cnt;
  logic              is_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;

  logic [DATA_W-1:0] ram [2**RAM_AW];

  logic              accept;
  logic              sel_ram;
  logic              sel_led;
  logic              sel_sw;
  logic [RAM_AW-1:0] ram_idx;
  logic              access_err;

  assign accept  = (state == S_IDLE) && ((mem_cmd == CMD_READ) || (mem_cmd == CMD_WRITE));
  assign sel_ram = ~addr_q[ADDR_W-1];
  assign sel_led = (addr_q == IO_LED_ADDR);
  assign sel_sw  = (addr_q == IO_SW_ADDR);
  assign ram_idx = addr_q[RAM_AW-1:0];

  // The switch port is read-only, so only a write to it is an error.
  always_comb begin
    access_err = 1'b1;
    if (sel_ram || sel_led) begin
      access_err = 1'b0;
    end else if (sel_sw) begin
      access_err = is_write_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      read_data  <= '0;
      led_out    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            is_write_q <= (mem_cmd == CMD_WRITE);
            addr_q     <= mem_addr;
            wdata_q    <= write_data;
            wait_cnt   <= WAIT_LOAD;
            if (WAIT_CYCLES > 0) state <= S_WAIT;
            else                 state <= S_ACCESS;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_ACCESS;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_ACCESS: begin
          state <= S_RESP;
          err_q <= access_err;
          if (is_write_q) begin
            if (!sel_ram && sel_led) led_out <= wdata_q;
          end else begin
            if (sel_ram)      read_data <= ram[ram_idx];
            else if (sel_led) read_data <= led_out;
            else if (sel_sw)  read_data <= sw_in;
            else              read_data <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  // RAM has no reset; a write whose closing edge sees reset_n=0 is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && (state == S_ACCESS) && is_write_q && sel_ram) begin
      ram[ram_idx] <= wdata_q;
    end
  end

  assign mem_busy  = (state != S_IDLE);
  assign mem_ready = (state == S_RESP);
  assign mem_err   = err_q;
  assign state_dbg = state;

endmodule

`default_nettype wire
